// File: rtl/instr_fetch.sv
// Titan-4 instruction fetch: owns the PC, fetches one instruction per memory
// req/ack transaction and holds it for decode until it is consumed.
module instr_fetch #(
  parameter int PC_W   = 8,
  parameter int OP_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [PC_W-1:0]        mem_addr,
  input  logic                   mem_ack,
  input  logic [OP_W+DATA_W-1:0] mem_rdata,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [OP_W-1:0]        opcode,
  output logic [DATA_W-1:0]      operand,
  output logic [PC_W-1:0]        pc_out,
  input  logic                   jmp_valid,
  input  logic [PC_W-1:0]        jmp_addr,
  input  logic                   halt
);

  // Handshakes: a memory transfer happens on an edge where mem_req && mem_ack;
  // an instruction is consumed on an edge where ir_valid && ir_ready. Both
  // mem_req and ir_valid come straight from the state register.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [OP_W-1:0]       opcode_q, opcode_d;
  logic [DATA_W-1:0]     operand_q, operand_d;
  logic [PC_W-1:0]       pc_out_q, pc_out_d;

  logic fetch_done;
  logic consume;

  assign fetch_done = (state_q == FETCH) && mem_ack;
  assign consume    = (state_q == HOLD) && ir_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ack) state_d = HOLD;
      HOLD:    if (ir_ready) state_d = halt ? HALTED : FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_req  = 1'b0;
    ir_valid = 1'b0;
    case (state_q)
      FETCH:   mem_req  = 1'b1;
      HOLD:    ir_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: halt takes priority over a jump, leaving the PC untouched.
  always_comb begin
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    pc_out_d  = pc_out_q;
    if (fetch_done) begin
      opcode_d  = mem_rdata[OP_W+DATA_W-1:DATA_W];
      operand_d = mem_rdata[DATA_W-1:0];
      pc_out_d  = pc_q;
      pc_d      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end else if (consume && !halt && jmp_valid) begin
      pc_d = jmp_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      pc_out_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign mem_addr = pc_q;
  assign opcode   = opcode_q;
  assign operand  = operand_q;
  assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, sequential fetch, backpressure,
// slow memory, jump/wrap, halt priority and asynchronous reset mid-operation.
module tb_instr_fetch;

  localparam int PC_W   = 8;
  localparam int OP_W   = 4;
  localparam int DATA_W = 4;

  logic                   clk;
  logic                   rst;
  logic                   mem_req;
  logic [PC_W-1:0]        mem_addr;
  logic                   mem_ack;
  logic [OP_W+DATA_W-1:0] mem_rdata;
  logic                   ir_valid;
  logic                   ir_ready;
  logic [OP_W-1:0]        opcode;
  logic [DATA_W-1:0]      operand;
  logic [PC_W-1:0]        pc_out;
  logic                   jmp_valid;
  logic [PC_W-1:0]        jmp_addr;
  logic                   halt;

  int n_cmp;
  int n_fail;

  instr_fetch #(.PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .opcode    (opcode),
    .operand   (operand),
    .pc_out    (pc_out),
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr),
    .halt      (halt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_hold(input string tag, input logic [3:0] op, input logic [3:0] od,
                            input logic [7:0] pco, input logic [7:0] addr);
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'd1);
    check({tag, ".mem_req"},  32'(mem_req),  32'd0);
    check({tag, ".opcode"},   32'(opcode),   32'(op));
    check({tag, ".operand"},  32'(operand),  32'(od));
    check({tag, ".pc_out"},   32'(pc_out),   32'(pco));
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] addr);
    check({tag, ".mem_req"},  32'(mem_req),  32'd1);
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'd0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, ".mem_req"},  32'(mem_req),  32'd0);
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'd0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, ".opcode"},   32'(opcode),   32'd0);
    check({tag, ".operand"},  32'(operand),  32'd0);
    check({tag, ".pc_out"},   32'(pc_out),   32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ir_ready  = 1'b0;
    jmp_valid = 1'b0;
    jmp_addr  = '0;
    halt      = 1'b0;

    // Reset held for two cycles, memory ready to ack immediately
    mem_ack = 1'b1;
    mem_rdata = 8'h3A;
    ir_ready = 1'b1;
    tick();
    tick();
    check_zeroed("reset");
    rst = 1'b1;

    // IDLE -> FETCH on first edge
    tick();
    check_fetch("start", 8'h00);

    // Sequential fetch, one instruction per two clocks
    tick();
    check_hold("seq0", 4'h3, 4'hA, 8'h00, 8'h01);
    mem_rdata = 8'h5F;
    tick();
    check_fetch("seq1f", 8'h01);
    tick();
    check_hold("seq1", 4'h5, 4'hF, 8'h01, 8'h02);

    // Backpressure: ready low for 4 cycles, jump offered meanwhile must be ignored
    ir_ready  = 1'b0;
    mem_ack   = 1'b0;
    jmp_valid = 1'b1;
    jmp_addr  = 8'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_hold("bp", 4'h5, 4'hF, 8'h01, 8'h02);
    end
    jmp_valid = 1'b0;
    ir_ready  = 1'b1;
    tick();
    ir_ready = 1'b0;
    check_fetch("bp_rel", 8'h02);

    // Slow memory: three cycles without ack, address must stay put
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch("slow", 8'h02);
    end
    mem_ack   = 1'b1;
    mem_rdata = 8'h7C;
    tick();
    mem_ack = 1'b0;
    check_hold("slow_done", 4'h7, 4'hC, 8'h02, 8'h03);

    // Jump to 0xFF, then the fetch from 0xFF wraps the PC to 0x00
    ir_ready  = 1'b1;
    jmp_valid = 1'b1;
    jmp_addr  = 8'hFF;
    tick();
    ir_ready  = 1'b0;
    jmp_valid = 1'b0;
    check_fetch("jump", 8'hFF);
    mem_ack   = 1'b1;
    mem_rdata = 8'h1E;
    tick();
    check_hold("wrap", 4'h1, 4'hE, 8'hFF, 8'h00);

    // Halt together with a jump: halt wins, PC unchanged, no more requests
    ir_ready  = 1'b1;
    halt      = 1'b1;
    jmp_valid = 1'b1;
    jmp_addr  = 8'h55;
    tick();
    halt      = 1'b0;
    jmp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("halted.mem_req",  32'(mem_req),  32'd0);
      check("halted.ir_valid", 32'(ir_valid), 32'd0);
      check("halted.mem_addr", 32'(mem_addr), 32'h00);
      tick();
    end

    // Leave HALTED through reset, then fetch a couple of instructions
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mem_ack = 1'b0;
    ir_ready = 1'b0;
    tick();
    check_fetch("restart", 8'h00);
    mem_ack   = 1'b1;
    mem_rdata = 8'h9B;
    tick();
    mem_ack = 1'b0;
    check_hold("restart0", 4'h9, 4'hB, 8'h00, 8'h01);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check_fetch("pre_rst_fetch", 8'h01);

    // Asynchronous reset in FETCH: outputs clear before the next edge
    #2;
    rst = 1'b0;
    #1;
    check_zeroed("rst_fetch");
    tick();
    rst = 1'b1;
    tick();
    check_fetch("after_rst_fetch", 8'h00);
    mem_ack   = 1'b1;
    mem_rdata = 8'h2D;
    tick();
    mem_ack = 1'b0;
    check_hold("pre_rst_hold", 4'h2, 4'hD, 8'h00, 8'h01);

    // Asynchronous reset in HOLD
    #3;
    rst = 1'b0;
    #1;
    check_zeroed("rst_hold");
    tick();
    rst = 1'b1;
    tick();
    check_fetch("after_rst_hold", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
